// File: rtl/change_mon_pkg.sv
// Shared constants and helpers for change_event_monitor: counter width,
// round-robin pick among pending channels and a saturating add.
package change_mon_pkg;

  localparam int CNT_W  = 16;
  localparam int MAX_CH = 64;  // widest request vector rr_pick accepts

  // Returns the first set request at or after start (wrapping over n), or -1.
  function automatic int rr_pick(input logic [MAX_CH-1:0] req, input int n, input int start);
    int pick;
    int idx;
    pick = -1;
    for (int k = MAX_CH - 1; k >= 0; k--) begin
      if (k < n) begin
        idx = start + k;
        if (idx >= n) idx = idx - n;
        if (req[idx]) pick = idx;
      end
    end
    return pick;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt,
                                               input logic [CNT_W-1:0] inc);
    logic [CNT_W:0] sum;
    sum = {1'b0, cnt} + {1'b0, inc};
    return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
  endfunction

endpackage

// File: rtl/evt_fifo.sv
// First-word-fall-through FIFO holding change records; async active-high reset
// clears pointers and count, storage is left uninitialised.
module evt_fifo #(
  parameter int  DW    = 8,
  parameter int  DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] pop_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]   cnt_reg;
  logic          do_push, do_pop;

  assign full     = (cnt_reg == (AW + 1)'(DEPTH));
  assign empty    = (cnt_reg == '0);
  assign count    = cnt_reg;
  assign pop_data = mem[rd_ptr_reg];
  assign do_pop   = pop & ~empty;
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign do_push  = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      cnt_reg    <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_reg <= cnt_reg + (AW + 1)'(1);
        2'b01:   cnt_reg <= cnt_reg - (AW + 1)'(1);
        default: cnt_reg <= cnt_reg;
      endcase
    end
  end

endmodule

// File: rtl/change_event_monitor.sv
// Multi-channel value-change monitor: net changes become coalesced {ch, old, new}
// records dispatched round-robin into a FWFT FIFO. Option: CHG_MON_TIMESTAMP_EN.
module change_event_monitor
  import change_mon_pkg::*;
#(
  parameter int  NCH   = 4,
  parameter int  W     = 8,
  parameter int  DEPTH = 8,
  parameter int  TS_W  = 16,
  localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1,
  localparam int FC_W  = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic [NCH*W-1:0] sig_i,
  output logic             evt_valid_o,
  input  logic             evt_ready_i,
  output logic [CH_W-1:0]  evt_ch_o,
  output logic [W-1:0]     evt_old_o,
  output logic [W-1:0]     evt_new_o,
`ifdef CHG_MON_TIMESTAMP_EN
  output logic [TS_W-1:0]  evt_ts_o,
`endif
  output logic [NCH-1:0]   pending_o,
  output logic [CNT_W-1:0] coal_cnt_o,
  output logic [FC_W-1:0]  fifo_cnt_o
);

`ifdef CHG_MON_TIMESTAMP_EN
  localparam bit TS_EN = 1'b1;
`else
  localparam bit TS_EN = 1'b0;
`endif
  localparam int DW = CH_W + 2 * W + (TS_EN ? TS_W : 0);

  typedef struct packed {
    logic [CH_W-1:0] ch;
    logic [W-1:0]    old_v;
    logic [W-1:0]    new_v;
`ifdef CHG_MON_TIMESTAMP_EN
    logic [TS_W-1:0] ts;
`endif
  } rec_t;

  logic [W-1:0]      prev_reg     [NCH];
  logic [W-1:0]      pend_old_reg [NCH];
  logic [W-1:0]      pend_new_reg [NCH];
  logic [W-1:0]      cur          [NCH];
  logic [NCH-1:0]    pending_reg;
  logic [CNT_W-1:0]  coal_cnt_reg, coal_inc;
  logic              primed_reg;
  logic [CH_W-1:0]   rr_ptr_reg, grant_idx;
  logic              grant_valid;
  logic [MAX_CH-1:0] req_ext;
  int                pick_int;
  logic [NCH-1:0]    chg, dispatched, coal_hit;
  logic              fifo_full, fifo_empty, push, pop;
  rec_t              push_rec, head_rec;
`ifdef CHG_MON_TIMESTAMP_EN
  logic [TS_W-1:0]   ts_cnt_reg;
  logic [TS_W-1:0]   pend_ts_reg [NCH];
`endif

  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    assign cur[gi]        = sig_i[gi*W +: W];
    assign chg[gi]        = primed_reg & en_i & (cur[gi] != prev_reg[gi]);
    assign dispatched[gi] = push & (grant_idx == CH_W'(gi));
    // A change on the dispatch edge opens a fresh record instead of coalescing.
    assign coal_hit[gi]   = chg[gi] & pending_reg[gi] & ~dispatched[gi];
  end

  always_comb begin
    req_ext            = '0;
    req_ext[NCH-1:0]   = pending_reg;
    pick_int           = rr_pick(req_ext, NCH, int'(rr_ptr_reg));
    grant_valid        = (pick_int >= 0);
    grant_idx          = pick_int[CH_W-1:0];
  end

  assign evt_valid_o = ~fifo_empty;
  assign pop         = evt_valid_o & evt_ready_i;
  assign push        = grant_valid & (~fifo_full | pop);

  always_comb begin
    push_rec       = '0;
    push_rec.ch    = grant_idx;
    push_rec.old_v = pend_old_reg[grant_idx];
    push_rec.new_v = pend_new_reg[grant_idx];
`ifdef CHG_MON_TIMESTAMP_EN
    push_rec.ts    = pend_ts_reg[grant_idx];
`endif
  end

  always_comb begin
    coal_inc = '0;
    for (int c = 0; c < NCH; c++) begin
      coal_inc = coal_inc + {{(CNT_W-1){1'b0}}, coal_hit[c]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      primed_reg   <= 1'b0;
      pending_reg  <= '0;
      coal_cnt_reg <= '0;
      rr_ptr_reg   <= '0;
      for (int c = 0; c < NCH; c++) begin
        prev_reg[c]     <= '0;
        pend_old_reg[c] <= '0;
        pend_new_reg[c] <= '0;
      end
    end else begin
      primed_reg   <= 1'b1;
      coal_cnt_reg <= sat_inc(coal_cnt_reg, coal_inc);
      if (push) rr_ptr_reg <= (grant_idx == CH_W'(NCH - 1)) ? '0 : grant_idx + CH_W'(1);
      for (int c = 0; c < NCH; c++) begin
        prev_reg[c] <= cur[c];
        if (chg[c]) begin
          if (!pending_reg[c] || dispatched[c]) begin
            pending_reg[c]  <= 1'b1;
            pend_old_reg[c] <= prev_reg[c];
            pend_new_reg[c] <= cur[c];
          end else if (cur[c] != pend_old_reg[c]) begin
            pend_new_reg[c] <= cur[c];
          end else begin
            pending_reg[c]  <= 1'b0;
          end
        end else if (dispatched[c]) begin
          pending_reg[c] <= 1'b0;
        end
      end
    end
  end

`ifdef CHG_MON_TIMESTAMP_EN
  // Stamp is taken when a record opens and survives later coalescing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ts_cnt_reg <= '0;
      for (int c = 0; c < NCH; c++) pend_ts_reg[c] <= '0;
    end else begin
      ts_cnt_reg <= ts_cnt_reg + TS_W'(1);
      for (int c = 0; c < NCH; c++) begin
        if (chg[c] && (!pending_reg[c] || dispatched[c])) pend_ts_reg[c] <= ts_cnt_reg;
      end
    end
  end

  assign evt_ts_o = evt_valid_o ? head_rec.ts : '0;
`endif

  evt_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_rec),
    .pop       (pop),
    .pop_data  (head_rec),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_cnt_o)
  );

  assign evt_ch_o   = evt_valid_o ? head_rec.ch    : '0;
  assign evt_old_o  = evt_valid_o ? head_rec.old_v : '0;
  assign evt_new_o  = evt_valid_o ? head_rec.new_v : '0;
  assign pending_o  = pending_reg;
  assign coal_cnt_o = coal_cnt_reg;

endmodule

// File: tb/tb_change_event_monitor.sv
// Scoreboard bench for change_event_monitor (default parameters): directed
// stimulus pushes expected records, a negedge monitor pops and compares.
module tb_change_event_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [31:0] sig;
  logic        ready;
  logic        evt_valid;
  logic [1:0]  evt_ch;
  logic [7:0]  evt_old, evt_new;
  logic [3:0]  pending;
  logic [15:0] coal;
  logic [3:0]  fifo_cnt;
`ifdef CHG_MON_TIMESTAMP_EN
  logic [15:0] evt_ts;
`endif

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [1:0] ch;
    logic [7:0] o;
    logic [7:0] n;
  } exp_t;
  exp_t exp_q[$];

  int         fc[10] = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 3};
  logic [7:0] fv[10] = '{8'hA0, 8'h21, 8'h32, 8'h43, 8'hA1, 8'h00, 8'h00, 8'h44, 8'hA2, 8'h45};

  change_event_monitor dut (
    .clk         (clk),
    .rst         (rst),
    .en_i        (en),
    .sig_i       (sig),
    .evt_valid_o (evt_valid),
    .evt_ready_i (ready),
    .evt_ch_o    (evt_ch),
    .evt_old_o   (evt_old),
    .evt_new_o   (evt_new),
`ifdef CHG_MON_TIMESTAMP_EN
    .evt_ts_o    (evt_ts),
`endif
    .pending_o   (pending),
    .coal_cnt_o  (coal),
    .fifo_cnt_o  (fifo_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int c, input logic [7:0] v);
    sig[c*8 +: 8] = v;
  endtask

  task automatic add_exp(input logic [1:0] c, input logic [7:0] o, input logic [7:0] n);
    exp_t e;
    e.ch = c;
    e.o  = o;
    e.n  = n;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    en    = 1'b1;
    ready = 1'b0;
    sig   = '0;
    repeat (2) step();
    rst = 1'b0;
  endtask

  // A negedge with valid & ready means the head leaves on the next rising edge.
  always @(negedge clk) begin
    if (!rst && evt_valid && ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_record: got ch=%0d old=%02h new=%02h, required none",
                 evt_ch, evt_old, evt_new);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        $display("record ch=%0d old=%02h new=%02h (want ch=%0d old=%02h new=%02h)",
                 evt_ch, evt_old, evt_new, e.ch, e.o, e.n);
        check("record", {14'd0, evt_ch, evt_old, evt_new}, {14'd0, e.ch, e.o, e.n});
      end
    end
  end

  initial begin
    logic [7:0] old_v;

    // Reset state
    do_reset();
    check("rst_valid", 32'(evt_valid), 32'd0);
    check("rst_fifo_cnt", 32'(fifo_cnt), 32'd0);
    check("rst_pending", 32'(pending), 32'd0);
    check("rst_coal", 32'(coal), 32'd0);
    check("rst_new", 32'(evt_new), 32'd0);
    step();  // priming edge

    // Single change, two-edge latency
    ready = 1'b1;
    set_ch(0, 8'h01);
    add_exp(2'd0, 8'h00, 8'h01);
    step();
    check("t1_pending", 32'(pending), 32'h1);
    check("t1_valid_early", 32'(evt_valid), 32'd0);
    step();
    check("t1_valid", 32'(evt_valid), 32'd1);
    check("t1_pending_clr", 32'(pending), 32'h0);
    step();

    // Change on the dispatch edge splits into two records
    set_ch(0, 8'h02);
    step();
    set_ch(0, 8'h03);
    add_exp(2'd0, 8'h01, 8'h02);
    add_exp(2'd0, 8'h02, 8'h03);
    step();
    check("split_reopen", 32'(pending), 32'h1);
    repeat (5) step();
    check("split_drained", 32'(fifo_cnt), 32'd0);

    // Disabled monitoring: prev tracks, nothing opens
    en = 1'b0;
    set_ch(1, 8'h5A);
    repeat (2) step();
    check("dis_pending", 32'(pending), 32'h0);
    check("dis_fifo", 32'(fifo_cnt), 32'd0);
    en = 1'b1;
    step();
    check("reen_pending", 32'(pending), 32'h0);

    // All channels at once, round-robin order from pointer 0
    do_reset();
    step();
    ready = 1'b1;
    sig = 32'h13121110;
    add_exp(2'd0, 8'h00, 8'h10);
    add_exp(2'd1, 8'h00, 8'h11);
    add_exp(2'd2, 8'h00, 8'h12);
    add_exp(2'd3, 8'h00, 8'h13);
    step();
    check("t4_pending", 32'(pending), 32'hF);
    repeat (8) step();
    check("t4_pending_clr", 32'(pending), 32'h0);
    check("t4_fifo", 32'(fifo_cnt), 32'd0);

    // Fill the FIFO with DEPTH+2 changes while stalled
    do_reset();
    step();
    for (int i = 0; i < 10; i++) begin
      old_v = sig[fc[i]*8 +: 8];
      set_ch(fc[i], fv[i]);
      if (i < 8) add_exp(fc[i][1:0], old_v, fv[i]);
      step();
    end
    check("full_cnt", 32'(fifo_cnt), 32'd8);
    check("full_pending", 32'(pending), 32'h9);
    check("full_valid", 32'(evt_valid), 32'd1);

    // Coalescing while back-pressured: last write wins
    set_ch(1, 8'h05);
    step();
    set_ch(1, 8'h07);
    step();
    check("coal_cnt1", 32'(coal), 32'd1);
    check("coal_pending", 32'(pending), 32'hB);

    // Net-zero change is suppressed
    set_ch(2, 8'hFF);
    step();
    check("nz_open", 32'(pending), 32'hF);
    set_ch(2, 8'h00);
    step();
    check("nz_pending", 32'(pending), 32'hB);
    check("nz_coal", 32'(coal), 32'd2);
    check("nz_fifo", 32'(fifo_cnt), 32'd8);

    // Drain: pointer sits at 0 after the last ch3 grant
    add_exp(2'd0, 8'hA1, 8'hA2);
    add_exp(2'd1, 8'h00, 8'h07);
    add_exp(2'd3, 8'h44, 8'h45);
    ready = 1'b1;
    step();
    check("full_push_pop", 32'(fifo_cnt), 32'd8);
    check("drain_pending", 32'(pending), 32'hA);
    repeat (14) step();
    check("drain_fifo", 32'(fifo_cnt), 32'd0);
    check("drain_pending_clr", 32'(pending), 32'h0);
    check("drain_valid", 32'(evt_valid), 32'd0);

    // Asynchronous reset with queued records
    ready = 1'b0;
    set_ch(0, 8'h01);
    set_ch(1, 8'h02);
    set_ch(2, 8'h03);
    repeat (5) step();
    check("pre_rst_cnt", 32'(fifo_cnt), 32'd3);
    #2;
    rst = 1'b1;
    #1;
    check("async_valid", 32'(evt_valid), 32'd0);
    check("async_fifo", 32'(fifo_cnt), 32'd0);
    check("async_pending", 32'(pending), 32'h0);
    check("async_new", 32'(evt_new), 32'd0);
    step();
    rst = 1'b0;
    step();

    check("queue_left", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
